shared_adder_sched: RTL
=======================

# shared_adder_sched

Time-multiplexes the single 10-bit ripple-carry adder across three requesters in the snake game datapath: head-X update, head-Y update, and score increment. Requesters post operands with a req/gnt handshake. The block arbitrates, latches the granted operands and sequences one addition through the adder. It then returns the registered sum with a per-requester done pulse. This removes two of the three adder instances from the top level.

## Interface
- N_REQ, 3, number of requesters; fixed at 3 for this design, range 2..4 supported
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- req_i  in  N_REQ  request per requester; level, held until granted
- a_i  in  10*N_REQ  operand A, packed; requester i at [10i+9:10i]
- b_i  in  10*N_REQ  operand B, packed likewise
- gnt_o  out  N_REQ  one-hot grant pulse, one cycle
- done_o  out  N_REQ  one-hot completion pulse, one cycle
- res_o  out  10  sum; valid only while done_o is nonzero
- busy_o  out  1  high whenever state is not IDLE

## Operation
- Arithmetic: res = (a + b) mod 1024.
  - No carry out.
  - No carry in; the adder's carry-in is tied to 0.
  - Decrement is done by passing b = 10'h3FF.
- States and transitions:
  - IDLE: if any req_i is set, pick a winner, pulse gnt_o[w], latch a_q/b_q/owner_q, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: a_q/b_q drive the adder. The sum is captured into res_q at the end of the cycle. Always go to DONE.
  - DONE: res_o = res_q and done_o[owner_q] = 1. Always go to IDLE.
- Arbitration (default): round-robin.
  - Search starts at (last_owner+1) mod N_REQ and takes the first active req_i.
  - last_owner updates only on a grant.
- Operands are sampled only in the grant cycle. Later changes to a_i/b_i do not affect the in-flight operation.
- A requester must drop req_i the cycle after gnt. If it keeps req_i high, that is a new request and is arbitrated normally.
- A req_i that deasserts before it is granted is never granted.
- Requests arriving during EXEC or DONE wait. They are evaluated in the next IDLE cycle.
- Outputs outside DONE: res_o = 0 and done_o = 0. res_o is never stale-visible.

## Timing
- Grant occurs in the same cycle as the req seen in IDLE, i.e. registered at the edge that ends that cycle.
  - Cycle 0: req seen in IDLE; gnt_o pulses in cycle 0's registered output (cycle 1 view: state = EXEC).
  - Cycle 2: done_o and res_o valid.
- Latency: req sampled → done is 2 cycles after gnt.
- Throughput: one operation per 3 cycles.
- The adder is given a full EXEC cycle to settle. Its ripple path is not registered inside the adder.
- Reset values: state = IDLE, gnt_o = 0, done_o = 0, res_o = 0, busy_o = 0, last_owner = N_REQ-1 (so requester 0 wins first), a_q = b_q = res_q = 0.
- Reset mid-operation: resetn sampled low at any state aborts the operation. No done pulse is issued, and all registers return to their reset values on that edge.
- Reset has priority over all other events in the same cycle.

## Configuration
- SHARED_ADDER_RR_EN defined: round-robin arbitration as described above.
- SHARED_ADDER_RR_EN undefined: fixed priority. Requester 0 is highest, then 1, then 2. last_owner is not implemented.
- Latency, handshake and reset behaviour are identical in both builds.

## Structure
- Shared package:
  - the state enum (IDLE, EXEC, DONE)
  - DATA_W = 10
  - requester index constants REQ_HEADX = 0, REQ_HEADY = 1, REQ_SCORE = 2
- Sub-module rr_pick: combinational arbiter. Inputs are req and last_owner; outputs are a one-hot winner and its index. It is compiled in either RR or fixed-priority form under the macro.
- The existing 10-bit ripple adder is instantiated once, with inputs a_q and b_q.

## Test plan
- Single add: req_i = 3'b001, a = 10'd37, b = 10'd5.
  - gnt_o = 001.
  - Two cycles later, done_o = 001 and res_o = 42.
  - busy_o is high for exactly 2 cycles after the grant edge.
- Wrap and decrement:
  - a = 10'd1000, b = 10'd30 → res_o = 6.
  - a = 10'd0, b = 10'h3FF → res_o = 10'h3FF.
- Contention with round-robin (RR_EN defined):
  - Hold req_i = 111 continuously.
  - Grants go 001, 010, 100, 001, spaced 3 cycles apart.
  - Each done carries that requester's own sum.
- Fixed priority (RR_EN undefined):
  - Hold req_i = 111; requester 0 wins every round.
  - Hold req_i = 110; requester 1 wins.
- Operand isolation: change a_i/b_i in the cycle after gnt. res_o still equals the sum of the values latched at gnt.
- Reset in EXEC: resetn = 0 for one cycle.
  - No done_o pulse follows.
  - All outputs are 0 on the next cycle.
  - A following req_i = 111 is granted to requester 0 first.

Source files
------------

// File: rtl/shared_adder_sched_pkg.sv
// Shared types and constants for the time-multiplexed snake datapath adder.
package shared_adder_sched_pkg;

  localparam int unsigned DATA_W    = 10;
  localparam int unsigned N_REQ     = 3;
  localparam int unsigned OWN_W     = 2;

  localparam int unsigned REQ_HEADX = 0;
  localparam int unsigned REQ_HEADY = 1;
  localparam int unsigned REQ_SCORE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shared_adder_sched_adder.sv
// The single 10-bit ripple-carry adder; carry-in tied low, carry-out dropped.
module shared_adder_sched_adder
  import shared_adder_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < DATA_W - 1; i++) begin : g_carry
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o = a_i ^ b_i ^ carry;

endmodule

// File: rtl/shared_adder_sched_rr_pick.sv
// Combinational arbiter: round-robin after last_i with SHARED_ADDER_RR_EN,
// otherwise fixed priority with requester 0 highest.
module shared_adder_sched_rr_pick
  import shared_adder_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
`ifdef SHARED_ADDER_RR_EN
  input  logic [OWN_W-1:0] last_i,
`endif
  output logic [N_REQ-1:0] win_c_o,
  output logic [OWN_W-1:0] idx_c_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    win_c_o = '0;
    idx_c_o = '0;
    cand    = 0;
    found   = 1'b0;
`ifdef SHARED_ADDER_RR_EN
    // Search order starts just past the last owner and wraps.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_i) + k) % N_REQ;
      if (!found && req_i[OWN_W'(cand)]) begin
        found                  = 1'b1;
        win_c_o[OWN_W'(cand)]  = 1'b1;
        idx_c_o                = OWN_W'(cand);
      end
    end
`else
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = k;
      if (!found && req_i[OWN_W'(cand)]) begin
        found                  = 1'b1;
        win_c_o[OWN_W'(cand)]  = 1'b1;
        idx_c_o                = OWN_W'(cand);
      end
    end
`endif
  end

endmodule

// File: rtl/shared_adder_sched.sv
// Shares one ripple adder between head-X, head-Y and score requesters.
// Arbitration is round-robin when SHARED_ADDER_RR_EN is defined, else fixed priority.
module shared_adder_sched
  import shared_adder_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [DATA_W*N_REQ-1:0]   a_i,
  input  logic [DATA_W*N_REQ-1:0]   b_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]         res_o,
  output logic                      busy_o
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [OWN_W-1:0]  owner_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
`ifdef SHARED_ADDER_RR_EN
  logic [OWN_W-1:0]  last_owner_q;
`endif

  logic [N_REQ-1:0]  win;
  logic [OWN_W-1:0]  win_idx;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] sum;

  shared_adder_sched_rr_pick u_rr_pick (
    .req_i   (req_i),
`ifdef SHARED_ADDER_RR_EN
    .last_i  (last_owner_q),
`endif
    .win_c_o (win),
    .idx_c_o (win_idx)
  );

  shared_adder_sched_adder u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum)
  );

  // Winner's operand slice, captured only on the grant edge.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == OWN_W'(k)) begin
        a_sel = a_i[k*DATA_W +: DATA_W];
        b_sel = b_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
`ifdef SHARED_ADDER_RR_EN
      last_owner_q <= OWN_W'(N_REQ - 1);
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            gnt_q        <= win;
            a_q          <= a_sel;
            b_q          <= b_sel;
            owner_q      <= win_idx;
`ifdef SHARED_ADDER_RR_EN
            last_owner_q <= win_idx;
`endif
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= sum;
          done_q  <= N_REQ'(1) << owner_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Clearing here keeps res_o at zero everywhere outside DONE.
          res_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          res_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign res_o  = res_q;
  assign busy_o = busy_q;

endmodule
